mem_refill_arbiter: RTL and testbench
=====================================

Name: mem_refill_arbiter

Overview:
- Sequences all main-memory traffic for the MIPS pipeline.
- Serves two cache requesters over one shared 128-bit main-memory port: requester 0 is the instruction cache, requester 1 is the data cache.
- Runs each dirty-miss writeback and line refill as timed main-memory accesses of fixed latency, returns the refill line, and drives per-requester wait flags for the pipeline stall logic.
- Replaces ad-hoc per-cache cycle counting with one central controller.

Parameters:
- MEM_LATENCY, 20: cycles each main-memory access (write or read) occupies; legal range is 2 or more.
- ADDR_W, 32: byte-address width.
- LINE_W, 128: cache line width (4 words).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req0, req1  in  1  refill request; held high until the matching done pulse.
- wb0, wb1  in  1  request includes a writeback of a dirty victim line; sampled at grant.
- fill_addr0, fill_addr1  in  ADDR_W  address of the missing line; sampled at grant.
- wb_addr0, wb_addr1  in  ADDR_W  victim line address; sampled at grant.
- wb_data0, wb_data1  in  LINE_W  victim line data; sampled at grant.
- done0, done1  out  1  one-cycle completion pulse.
- fill_data0, fill_data1  out  LINE_W  refill line; valid from the done pulse, held until the next done for that requester.
- wait0, wait1  out  1  pipeline stall = reqN & ~doneN (combinational).
- mem_write  out  1  main-memory write strobe, held for the whole access.
- mem_read  out  1  main-memory read strobe, held for the whole access.
- mem_addr  out  ADDR_W  line-aligned access address (bits [3:0] forced to 0).
- mem_wdata  out  LINE_W  writeback data.
- mem_rdata  in  LINE_W  main-memory read data; valid on the last access cycle.

Behaviour:
- Clocking and reset: single clock domain, one clock `clk`; reset is synchronous and active-high on port `reset`.
- Reset values:
  - state IDLE, access counter 0.
  - done0/1, mem_write, mem_read = 0.
  - mem_addr, mem_wdata, fill_data0/1 = 0.
  - arbitration pointer favours requester 1 first.
- FSM states: IDLE, WRITEBACK, FILL, RESP.
- IDLE:
  - If any req is high at an edge, grant one requester (see arbitration).
  - On grant, latch the granted requester's fill_addr, wb, wb_addr and wb_data, and clear the counter.
  - Next state is WRITEBACK if wb=1, else FILL.
- WRITEBACK:
  - mem_write=1, mem_addr={wb_addr[31:4],4'b0}, mem_wdata=latched wb_data.
  - Counter runs 0..MEM_LATENCY-1; on the edge with count==MEM_LATENCY-1, go to FILL and clear the counter.
- FILL:
  - mem_read=1, mem_addr={fill_addr[31:4],4'b0}.
  - On the edge with count==MEM_LATENCY-1, capture mem_rdata into the granted requester's fill_data and go to RESP.
- RESP:
  - The granted requester's done is high for exactly one cycle; mem_read and mem_write are 0.
  - Next state IDLE.
- Latency, counted from the IDLE sampling edge:
  - done rises MEM_LATENCY edges later without writeback, 2*MEM_LATENCY edges later with writeback.
  - Minimum gap between back-to-back grants: one IDLE cycle after RESP.
- Strobes: mem_write and mem_read are never high together. mem_addr and mem_wdata are stable for the whole access.
- Arbitration (default): fixed priority, req1 over req0. Ties are resolved only in IDLE. A request that arrives while the controller is busy waits; it is never dropped.
- Protocol:
  - The requester drops req in the cycle after done.
  - A req still high in IDLE after RESP is treated as a new request.
  - A req deasserted mid-service is illegal. The controller still completes the access and pulses done, and the pulse is ignored.
- Reset mid-operation:
  - The current access is abandoned; strobes are 0 after the reset edge.
  - No done is issued and latched data is discarded.
  - Requesters re-request after reset.
- Counter width: $clog2(MEM_LATENCY); no wrap beyond MEM_LATENCY-1.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. A 1-bit last-grant pointer is updated at each grant. When both requesters are pending, the one not granted last wins. Reset pointer makes requester 1 win the first tie.
- Undefined: fixed priority, req1 > req0; no pointer register.

Test Plan:
- Plain refill: req0=1, wb0=0, fill_addr0=0x0000_1234, mem_rdata=0xAAAA…AA on the last cycle -> mem_read high 20 cycles with mem_addr=0x0000_1230; done0 pulses at edge 20; fill_data0=0xAAAA…AA; wait0 high until done0.
- Dirty miss: req1=1, wb1=1, wb_addr1=0x0004_0010, wb_data1=0x1111…11, fill_addr1=0x0008_0020 -> mem_write 20 cycles at 0x0004_0010 with data 0x1111…11, then mem_read 20 cycles at 0x0008_0020; done1 at edge 40; strobes never overlap.
- Simultaneous requests, macro undefined, no writebacks -> req1 served first with done1 at edge 20; req0 sampled at edge 22 and done0 at edge 42; wait0 high throughout.
- Round robin, MEM_ARB_ROUND_ROBIN_EN defined, both reqs re-asserted after every done -> grant order 1,0,1,0. Same stimulus with the macro undefined -> only requester 1 is served while req1 stays high.
- Reset mid-writeback: assert reset at edge 10 of WRITEBACK -> mem_write=0 after the reset edge, no done pulse, state IDLE. A re-issued request then completes normally at edge 20 / 40.
- MEM_LATENCY=2: plain refill -> mem_read high 2 cycles and done at edge 2. Writeback refill -> done at edge 4.

Source files
------------

// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: central main-memory sequencer for the instruction cache
// (requester 0) and data cache (requester 1). Each grant runs an optional
// dirty-line writeback followed by a line refill, each lasting MEM_LATENCY
// cycles, then pulses the requester's done for one cycle.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it requester 1 has fixed priority over requester 0.
module mem_refill_arbiter #(
  parameter int MEM_LATENCY = 20,
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wb0,
  input  logic              wb1,
  input  logic [ADDR_W-1:0] fill_addr0,
  input  logic [ADDR_W-1:0] fill_addr1,
  input  logic [ADDR_W-1:0] wb_addr0,
  input  logic [ADDR_W-1:0] wb_addr1,
  input  logic [LINE_W-1:0] wb_data0,
  input  logic [LINE_W-1:0] wb_data1,
  output logic              done0,
  output logic              done1,
  output logic [LINE_W-1:0] fill_data0,
  output logic [LINE_W-1:0] fill_data1,
  output logic              wait0,
  output logic              wait1,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, RESP} state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  count;
  logic              cnt_last;
  logic              any_req;
  logic              sel;
  logic              sel_wb;
  logic [ADDR_W-1:0] sel_fill_addr;
  logic [ADDR_W-1:0] sel_wb_addr;
  logic [LINE_W-1:0] sel_wb_data;
  logic              gnt;
  logic [ADDR_W-1:0] fill_addr_q;

  // Main memory works on whole lines: drop the byte-in-line offset.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:4], 4'b0000};
  endfunction

  assign cnt_last = (count == CNT_LAST);
  assign any_req  = req0 | req1;
  assign wait0    = req0 & ~done0;
  assign wait1    = req1 & ~done1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_gnt;

  // On a tie the requester not granted last wins; a lone request always wins.
  always_comb begin
    sel = req1;
    if (req0 && req1) sel = ~last_gnt;
  end

  // Last-grant pointer; reset value 0 lets requester 1 win the first tie.
  always_ff @(posedge clk) begin
    if (reset)                        last_gnt <= 1'b0;
    else if (state == IDLE && any_req) last_gnt <= sel;
  end
`else
  assign sel = req1;
`endif

  assign sel_wb        = sel ? wb1        : wb0;
  assign sel_fill_addr = sel ? fill_addr1 : fill_addr0;
  assign sel_wb_addr   = sel ? wb_addr1   : wb_addr0;
  assign sel_wb_data   = sel ? wb_data1   : wb_data0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: optional writeback, refill, one-cycle response.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (any_req) next_state = sel_wb ? WRITEBACK : FILL;
      WRITEBACK: if (cnt_last) next_state = FILL;
      FILL:      if (cnt_last) next_state = RESP;
      RESP:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Access counter, memory strobes/address/data, refill capture and done pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      gnt         <= 1'b0;
      fill_addr_q <= '0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      fill_data0  <= '0;
      fill_data1  <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt         <= sel;
            count       <= '0;
            fill_addr_q <= sel_fill_addr;
            mem_wdata   <= sel_wb_data;
            if (sel_wb) begin
              mem_write <= 1'b1;
              mem_addr  <= line_align(sel_wb_addr);
            end else begin
              mem_read  <= 1'b1;
              mem_addr  <= line_align(sel_fill_addr);
            end
          end
        end
        WRITEBACK: begin
          if (cnt_last) begin
            count     <= '0;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= line_align(fill_addr_q);
          end else begin
            count <= count + 1'b1;
          end
        end
        FILL: begin
          if (cnt_last) begin
            count    <= '0;
            mem_read <= 1'b0;
            if (gnt) begin
              fill_data1 <= mem_rdata;
              done1      <= 1'b1;
            end else begin
              fill_data0 <= mem_rdata;
              done0      <= 1'b1;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// tb_mem_refill_arbiter: table-driven single-requester transactions plus
// hand-written arbitration, reset and short-latency sequences. Completions are
// matched against a scoreboard queue of {requester, line, done edge}.
module tb_mem_refill_arbiter;

  localparam int L  = 20;
  localparam int L2 = 2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         req0, req1, wb0, wb1;
  logic [31:0]  fill_addr0, fill_addr1, wb_addr0, wb_addr1;
  logic [127:0] wb_data0, wb_data1;
  logic         done0, done1, wait0, wait1, mem_write, mem_read;
  logic [127:0] fill_data0, fill_data1, mem_wdata, mem_rdata;
  logic [31:0]  mem_addr;

  logic         b_req0, b_req1, b_wb0, b_wb1;
  logic [31:0]  b_fill_addr0, b_fill_addr1, b_wb_addr0, b_wb_addr1;
  logic [127:0] b_wb_data0, b_wb_data1;
  logic         b_done0, b_done1, b_wait0, b_wait1, b_mem_write, b_mem_read;
  logic [127:0] b_fill_data0, b_fill_data1, b_mem_wdata, b_mem_rdata;
  logic [31:0]  b_mem_addr;

  mem_refill_arbiter #(.MEM_LATENCY(L), .ADDR_W(32), .LINE_W(128)) u_dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .wb0(wb0), .wb1(wb1),
    .fill_addr0(fill_addr0), .fill_addr1(fill_addr1),
    .wb_addr0(wb_addr0), .wb_addr1(wb_addr1),
    .wb_data0(wb_data0), .wb_data1(wb_data1),
    .done0(done0), .done1(done1), .fill_data0(fill_data0), .fill_data1(fill_data1),
    .wait0(wait0), .wait1(wait1), .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_refill_arbiter #(.MEM_LATENCY(L2), .ADDR_W(32), .LINE_W(128)) u_dut2 (
    .clk(clk), .reset(reset), .req0(b_req0), .req1(b_req1), .wb0(b_wb0), .wb1(b_wb1),
    .fill_addr0(b_fill_addr0), .fill_addr1(b_fill_addr1),
    .wb_addr0(b_wb_addr0), .wb_addr1(b_wb_addr1),
    .wb_data0(b_wb_data0), .wb_data1(b_wb_data1),
    .done0(b_done0), .done1(b_done1), .fill_data0(b_fill_data0), .fill_data1(b_fill_data1),
    .wait0(b_wait0), .wait1(b_wait1), .mem_write(b_mem_write), .mem_read(b_mem_read),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Memory models: the true line appears only on the last read cycle.
  int           rd_cnt, b_rd_cnt;
  bit           addr_mode;
  logic [127:0] cur_line, b_line, model_line;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {4{a ^ 32'hC0DE_0000}};
  endfunction

  always @(posedge clk) rd_cnt   <= (reset || !mem_read)   ? 0 : rd_cnt + 1;
  always @(posedge clk) b_rd_cnt <= (reset || !b_mem_read) ? 0 : b_rd_cnt + 1;
  assign model_line  = addr_mode ? line_of(mem_addr) : cur_line;
  assign mem_rdata   = (mem_read && rd_cnt == L - 1) ? model_line : ~model_line;
  assign b_mem_rdata = (b_mem_read && b_rd_cnt == L2 - 1) ? b_line : ~b_line;

  typedef struct {
    bit           id;
    logic [127:0] data;
    int           edge_no;
  } sb_t;

  typedef struct {
    bit           id;
    bit           wb;
    logic [31:0]  fa;
    logic [31:0]  wa;
    logic [127:0] wd;
    logic [127:0] line;
    logic [31:0]  exp_raddr;
    logic [31:0]  exp_waddr;
    int           exp_wr;
    int           exp_lat;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[4];
  int   n_pass, n_total, edge_n, wait_bad, overlap_n;
  bit   auto_drop, drop0, drop1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock: sample after the edge, match completions, apply requester drops.
  task automatic step();
    sb_t e;
    @(posedge clk);
    #1;
    edge_n++;
    if (mem_write && mem_read) overlap_n++;
    if (done0 && done1) overlap_n++;
    if (wait0 !== (req0 & ~done0)) wait_bad++;
    if (wait1 !== (req1 & ~done1)) wait_bad++;
    if (done0 || done1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: done0=%0b done1=%0b at edge %0d, expected none", done0, done1, edge_n);
      end else begin
        e = sb.pop_front();
        chk("done_id", done1, e.id);
        chk("done_edge", edge_n, e.edge_no);
        chk("fill_data", done1 ? fill_data1 : fill_data0, e.data);
      end
    end
    if (drop0) begin req0 = 1'b0; drop0 = 1'b0; end
    if (drop1) begin req1 = 1'b0; drop1 = 1'b0; end
    if (auto_drop && done0) drop0 = 1'b1;
    if (auto_drop && done1) drop1 = 1'b1;
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0; b_req0 = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic run_vec(input vec_t v);
    int wr_n, rd_n, bad;
    wr_n = 0; rd_n = 0; bad = 0; wait_bad = 0; overlap_n = 0;
    cur_line = v.line; addr_mode = 1'b0; auto_drop = 1'b1;
    fill_addr0 = v.id ? 32'h1357_9BDF : v.fa;
    fill_addr1 = v.id ? v.fa : 32'h2468_ACE0;
    wb_addr0   = v.id ? 32'h0DEC_0DE0 : v.wa;
    wb_addr1   = v.id ? v.wa : 32'h0BAD_BAD0;
    wb_data0   = v.id ? ~v.wd : v.wd;
    wb_data1   = v.id ? v.wd : ~v.wd;
    wb0        = v.id ? 1'b1 : v.wb;
    wb1        = v.id ? v.wb : 1'b1;
    if (v.id) req1 = 1'b1; else req0 = 1'b1;
    sb.push_back('{v.id, v.line, edge_n + 1 + v.exp_lat});
    for (int k = 0; k < 3 * L && sb.size() != 0; k++) begin
      step();
      if (mem_write) begin
        wr_n++;
        if (mem_addr !== v.exp_waddr || mem_wdata !== v.wd || rd_n != 0) bad++;
      end
      if (mem_read) begin
        rd_n++;
        if (mem_addr !== v.exp_raddr) bad++;
      end
    end
    chk("done_timeout", sb.size(), 0);
    step(); step(); step();
    chk("wr_cycles", wr_n, v.exp_wr);
    chk("rd_cycles", rd_n, L);
    chk("strobe_addr_data", bad, 0);
    chk("wait_flags", wait_bad, 0);
    chk("strobe_overlap", overlap_n, 0);
    chk("fill_hold", v.id ? fill_data1 : fill_data0, v.line);
  endtask

  task automatic l2_run(input bit wb, input logic [127:0] line, input int exp_lat);
    int t0, done_at, rd, wr, dn, bad;
    rd = 0; wr = 0; dn = 0; bad = 0; done_at = -1;
    b_line = line; b_wb0 = wb; b_req0 = 1'b1;
    t0 = edge_n + 1;
    for (int k = 0; k < 4 * L2 + 6 && done_at < 0; k++) begin
      step();
      if (b_mem_read) begin
        rd++;
        if (b_mem_addr !== 32'h0000_0040) bad++;
      end
      if (b_mem_write) begin
        wr++;
        if (b_mem_addr !== 32'h0000_0F00 || b_mem_wdata !== b_wb_data0) bad++;
      end
      if (b_mem_read && b_mem_write) bad++;
      if (b_wait0 !== (b_req0 & ~b_done0) || b_wait1 !== 1'b0 || b_done1) bad++;
      if (b_done0) begin dn++; done_at = edge_n; end
    end
    step();
    if (b_done0) dn++;
    b_req0 = 1'b0;
    step();
    if (b_done0) dn++;
    step();
    if (b_done0) dn++;
    chk("l2_done_edge", done_at, t0 + exp_lat);
    chk("l2_rd_cycles", rd, L2);
    chk("l2_wr_cycles", wr, wb ? L2 : 0);
    chk("l2_done_pulses", dn, 1);
    chk("l2_strobes", bad, 0);
    chk("l2_fill", b_fill_data0, line);
  endtask

  initial begin
    int bad, g;
    vecs[0] = '{1'b0, 1'b0, 32'h0000_1234, 32'h0000_0000, '0, {32{4'hA}},
                32'h0000_1230, 32'h0000_0000, 0, L};
    vecs[1] = '{1'b1, 1'b1, 32'h0008_0020, 32'h0004_0010, {32{4'h1}}, {32{4'h5}},
                32'h0008_0020, 32'h0004_0010, L, 2 * L};
    vecs[2] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_ABCF,
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, {16{8'h3C}},
                32'hFFFF_FFF0, 32'h0000_ABC0, L, 2 * L};
    vecs[3] = '{1'b1, 1'b0, 32'h8000_000C, 32'h0000_0000, '0,
                128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978,
                32'h8000_0000, 32'h0000_0000, 0, L};

    n_pass = 0; n_total = 0; edge_n = 0; auto_drop = 1'b0; drop0 = 1'b0; drop1 = 1'b0;
    addr_mode = 1'b0; cur_line = '0; b_line = '0;
    req0 = 0; req1 = 0; wb0 = 0; wb1 = 0;
    fill_addr0 = '0; fill_addr1 = '0; wb_addr0 = '0; wb_addr1 = '0; wb_data0 = '0; wb_data1 = '0;
    b_req0 = 0; b_req1 = 0; b_wb0 = 0; b_wb1 = 0;
    b_fill_addr0 = 32'h0000_0047; b_fill_addr1 = 32'h0000_9990;
    b_wb_addr0 = 32'h0000_0F0F; b_wb_addr1 = 32'h0000_8880;
    b_wb_data0 = {4{32'h7777_1234}}; b_wb_data1 = '0;
    reset = 1'b1;

    // Reset state
    step(); step();
    chk("rst_done0", done0, 1'b0);
    chk("rst_done1", done1, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 128'h0);
    chk("rst_fill_data0", fill_data0, 128'h0);
    chk("rst_fill_data1", fill_data1, 128'h0);
    chk("rst_wait0", wait0, 1'b0);
    reset = 1'b0;
    step();

    // Single-requester transactions from the vector table
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Simultaneous requests without writeback
    addr_mode = 1'b1; auto_drop = 1'b1; wait_bad = 0; overlap_n = 0;
    wb0 = 0; wb1 = 0; fill_addr0 = 32'h0000_2004; fill_addr1 = 32'h0000_3008;
    req0 = 1'b1; req1 = 1'b1;
    sb.push_back('{1'b1, line_of(32'h0000_3000), edge_n + 1 + L});
    sb.push_back('{1'b0, line_of(32'h0000_2000), edge_n + 1 + 2 * L + 2});
    for (int k = 0; k < 4 * L && sb.size() != 0; k++) step();
    chk("simul_timeout", sb.size(), 0);
    step(); step(); step();
    chk("simul_wait", wait_bad, 0);
    chk("simul_overlap", overlap_n, 0);

    // Both requests held high across four services
    do_reset();
    auto_drop = 1'b0; overlap_n = 0;
    fill_addr0 = 32'h0000_4000; fill_addr1 = 32'h0000_5000;
    req0 = 1'b1; req1 = 1'b1;
    g = edge_n + 1;
    for (int i = 0; i < 4; i++) begin
      bit id;
      id = RR ? (i % 2 == 0) : 1'b1;
      sb.push_back('{id, line_of(id ? 32'h0000_5000 : 32'h0000_4000), g + i * (L + 2) + L});
    end
    for (int k = 0; k < 5 * (L + 2) && sb.size() != 0; k++) step();
    req0 = 1'b0; req1 = 1'b0;
    chk("arb_timeout", sb.size(), 0);
    for (int k = 0; k < 4; k++) step();
    chk("arb_overlap", overlap_n, 0);
    chk("arb_idle_read", mem_read, 1'b0);

    // Reset during writeback, then a clean re-request
    addr_mode = 1'b0; auto_drop = 1'b1;
    wb1 = 1'b1; wb_addr1 = 32'h0004_0010; wb_data1 = {32{4'h1}}; fill_addr1 = 32'h0008_0020;
    req1 = 1'b1;
    for (int k = 0; k < 11; k++) step();
    chk("wb_before_reset", mem_write, 1'b1);
    reset = 1'b1;
    step();
    chk("rst_mid_write", mem_write, 1'b0);
    chk("rst_mid_read", mem_read, 1'b0);
    chk("rst_mid_done", done1, 1'b0);
    req1 = 1'b0;
    step();
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (mem_write || mem_read || done0 || done1) bad++;
    end
    chk("rst_mid_idle", bad, 0);
    run_vec(vecs[1]);

    // Short latency instance: plain refill then writeback refill
    l2_run(1'b0, {4{32'hBEEF_0001}}, L2);
    l2_run(1'b1, {4{32'h0BAD_F00D}}, 2 * L2);
    chk("l2_fill1_idle", b_fill_data1, 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
